// File: rtl/fm_radio_pkg.sv
// Shared constants, types and helpers for the FM audio chain.
package fm_radio_pkg;

  // Fractional bits of the fixed-point coefficients.
  localparam int QUANT_BITS = 10;

  // De-emphasis coefficients in Q10. A1 is added into the sum, not subtracted.
  localparam int IIR_B0 = 178;
  localparam int IIR_B1 = 178;
  localparam int IIR_A1 = 666;

  // Sequencer states of the de-emphasis filter.
  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_MULT  = 2'd1,
    S_ACC   = 2'd2,
    S_WRITE = 2'd3
  } iir_state_t;

  // Signed divide by 2^qbits, truncating toward zero. Negative values get a
  // bias of 2^qbits-1 so the arithmetic shift rounds toward zero instead of
  // toward minus infinity. Callers sign-extend into 128 bits and truncate the
  // result to their own width.
  function automatic logic signed [127:0] dequant(input logic signed [127:0] sum,
                                                  input int qbits);
    logic signed [127:0] bias;
    logic signed [127:0] adj;
    bias = (128'sd1 <<< qbits) - 128'sd1;
    adj  = (sum < 0) ? (sum + bias) : sum;
    return adj >>> qbits;
  endfunction

endpackage

// File: rtl/fifo.sv
// Small synchronous first-word-fall-through FIFO used by the standalone wrapper.
module fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              empty
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push, pop;

  assign full  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;
  // Head word is always visible on dout.
  assign dout  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  // Pointer registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/iir_deemph_top.sv
// Standalone wrapper: input FIFO -> de-emphasis core -> output FIFO.
module iir_deemph_top #(
  parameter int DATA_SIZE  = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_wr_en,
  input  logic [DATA_SIZE-1:0] in_din,
  output logic                 in_full,
  input  logic                 out_rd_en,
  output logic [DATA_SIZE-1:0] out_dout,
  output logic                 out_empty
);
  logic [DATA_SIZE-1:0] core_in;
  logic [DATA_SIZE-1:0] core_out;
  logic                 core_in_empty, core_in_rd_en;
  logic                 core_out_full, core_out_wr_en;

  fifo #(.DATA_W(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (in_wr_en),
    .din   (in_din),
    .full  (in_full),
    .rd_en (core_in_rd_en),
    .dout  (core_in),
    .empty (core_in_empty)
  );

  iir_deemph #(.DATA_SIZE(DATA_SIZE)) u_core (
    .clock     (clock),
    .reset     (reset),
    .in_dout   (core_in),
    .in_empty  (core_in_empty),
    .in_rd_en  (core_in_rd_en),
    .out_din   (core_out),
    .out_full  (core_out_full),
    .out_wr_en (core_out_wr_en)
  );

  fifo #(.DATA_W(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (core_out_wr_en),
    .din   (core_out),
    .full  (core_out_full),
    .rd_en (out_rd_en),
    .dout  (out_dout),
    .empty (out_empty)
  );

endmodule

// File: rtl/iir_deemph.sv
// First-order de-emphasis IIR: y[n] = DEQUANT(B0*x[n] + B1*x[n-1] + A1*y[n-1]).
// One sample per four cycles: read, multiply, accumulate, write.
module iir_deemph
  import fm_radio_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int QUANT_BITS = fm_radio_pkg::QUANT_BITS
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic signed [DATA_SIZE-1:0] in_dout,
  input  logic                        in_empty,
  output logic                        in_rd_en,
  output logic signed [DATA_SIZE-1:0] out_din,
  input  logic                        out_full,
  output logic                        out_wr_en
);
  // Products and sum are double width; sums wrap with no saturation.
  // The dequant helper works in 128 bits, so DATA_SIZE must stay below 64.
  localparam int SUM_W = 2 * DATA_SIZE;
  typedef logic signed [SUM_W-1:0] wide_t;

  localparam wide_t B0_W = wide_t'(IIR_B0);
  localparam wide_t B1_W = wide_t'(IIR_B1);
  localparam wide_t A1_W = wide_t'(IIR_A1);

  iir_state_t                 state_q, state_d;
  logic signed [DATA_SIZE-1:0] x_reg_q, x_reg_d;
  logic signed [DATA_SIZE-1:0] x1_q, x1_d;
  logic signed [DATA_SIZE-1:0] y1_q, y1_d;
  logic signed [DATA_SIZE-1:0] y_reg_q, y_reg_d;
  wide_t                       prod0_q, prod0_d;
  wide_t                       prod1_q, prod1_d;
  wide_t                       prod2_q, prod2_d;

  wide_t               x_w, x1_w, y1_w, sum_w;
  logic signed [127:0] sum_ext;

  assign x_w     = {{DATA_SIZE{x_reg_q[DATA_SIZE-1]}}, x_reg_q};
  assign x1_w    = {{DATA_SIZE{x1_q[DATA_SIZE-1]}}, x1_q};
  assign y1_w    = {{DATA_SIZE{y1_q[DATA_SIZE-1]}}, y1_q};
  assign sum_w   = prod0_q + prod1_q + prod2_q;
  assign sum_ext = {{(128-SUM_W){sum_w[SUM_W-1]}}, sum_w};

  // FIFO handshakes come straight from the state and are held off in reset.
  assign in_rd_en  = reset && (state_q == S_READ)  && !in_empty;
  assign out_wr_en = reset && (state_q == S_WRITE) && !out_full;
  assign out_din   = reset ? y_reg_q : '0;

  // Sequencer and datapath next-state. History moves only on a successful
  // write, so a stalled output never disturbs the recursion.
  always_comb begin
    state_d = state_q;
    x_reg_d = x_reg_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    y_reg_d = y_reg_q;
    prod0_d = prod0_q;
    prod1_d = prod1_q;
    prod2_d = prod2_q;
    case (state_q)
      S_READ: begin
        if (!in_empty) begin
          x_reg_d = in_dout;
          state_d = S_MULT;
        end
      end
      S_MULT: begin
        prod0_d = B0_W * x_w;
        prod1_d = B1_W * x1_w;
        prod2_d = A1_W * y1_w;
        state_d = S_ACC;
      end
      S_ACC: begin
        y_reg_d = DATA_SIZE'(dequant(sum_ext, QUANT_BITS));
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!out_full) begin
          x1_d    = x_reg_q;
          y1_d    = y_reg_q;
          state_d = S_READ;
        end
      end
      default: state_d = S_READ;
    endcase
  end

  // State registers; reset clears history and discards any in-flight sample.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_READ;
      x_reg_q <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      y_reg_q <= '0;
      prod0_q <= '0;
      prod1_q <= '0;
      prod2_q <= '0;
    end else begin
      state_q <= state_d;
      x_reg_q <= x_reg_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      y_reg_q <= y_reg_d;
      prod0_q <= prod0_d;
      prod1_q <= prod1_d;
      prod2_q <= prod2_d;
    end
  end

endmodule

// File: tb/tb_iir_deemph.sv
// Directed bench for the de-emphasis core: reset, impulse, truncation,
// backpressure, streaming and mid-operation reset.
module tb_iir_deemph;
  localparam int DW = 32;

  logic                 clock = 1'b0;
  logic                 reset;
  logic signed [DW-1:0] in_dout;
  logic                 in_empty;
  logic                 in_rd_en;
  logic signed [DW-1:0] out_din;
  logic                 out_full;
  logic                 out_wr_en;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  iir_deemph #(.DATA_SIZE(DW), .QUANT_BITS(10)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_dout   (in_dout),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out_din   (out_din),
    .out_full  (out_full),
    .out_wr_en (out_wr_en)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference recursion; SV integer division truncates toward zero.
  function automatic longint golden(longint x, longint x1, longint y1);
    return (178 * x + 178 * x1 + 666 * y1) / 1024;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b0;
    in_empty = 1'b1;
    out_full = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Offer one sample, then expect exactly one write 3 cycles after the read.
  task automatic do_sample(input string tag, input logic signed [DW-1:0] x,
                           input longint exp);
    bit got;
    int k;
    @(negedge clock);
    in_dout  = x;
    in_empty = 1'b0;
    #1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_rd_en) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
      #1;
    end
    check({tag, "_rd"}, got, 1);
    if (!got) return;
    @(negedge clock);
    in_empty = 1'b1;
    #1;
    got = 1'b0;
    k   = -1;
    for (int i = 1; i <= 20; i++) begin
      if (out_wr_en) begin
        got = 1'b1;
        k   = i;
        break;
      end
      @(negedge clock);
      #1;
    end
    check({tag, "_lat"}, k, 3);
    if (got) check({tag, "_val"}, out_din, exp);
    $display("sample %s x=%0d y=%0d", tag, x, out_din);
  endtask

  logic signed [DW-1:0] sx [64];
  longint               ex [64];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with data waiting: no handshakes, zero output.
    reset    = 1'b0;
    in_empty = 1'b0;
    in_dout  = 32'sd5;
    out_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      check("rst_rd", in_rd_en, 0);
      check("rst_wr", out_wr_en, 0);
      check("rst_din", out_din, 0);
    end
    @(negedge clock);
    reset    = 1'b1;
    in_empty = 1'b1;

    // Impulse response from cleared history.
    do_sample("imp0", 32'sd1024, 178);
    do_sample("imp1", 32'sd0, 293);
    do_sample("imp2", 32'sd0, 190);

    // Truncation toward zero for negative sums.
    do_reset();
    do_sample("neg1", -32'sd1, 0);
    do_reset();
    do_sample("neg1024", -32'sd1024, -178);

    // Backpressure: stall 5 cycles in the write state holding 178.
    do_reset();
    @(negedge clock);
    in_dout  = 32'sd1024;
    in_empty = 1'b0;
    out_full = 1'b1;
    #1;
    check("bp_rd", in_rd_en, 1);
    @(negedge clock);
    in_dout = 32'sd0;
    @(negedge clock);
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_stall_wr", out_wr_en, 0);
      check("bp_stall_rd", in_rd_en, 0);
      check("bp_stall_din", out_din, 178);
      @(negedge clock);
    end
    out_full = 1'b0;
    #1;
    check("bp_release_wr", out_wr_en, 1);
    check("bp_release_din", out_din, 178);
    in_empty = 1'b1;
    @(negedge clock);
    #1;
    check("bp_single_wr", out_wr_en, 0);
    do_sample("bp_next", 32'sd0, 293);

    // Mid-operation reset during accumulate discards the sample.
    do_reset();
    @(negedge clock);
    in_dout  = 32'sd1024;
    in_empty = 1'b0;
    #1;
    check("mid_rd", in_rd_en, 1);
    @(negedge clock);
    in_empty = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("mid_nowrite", out_wr_en, 0);
      @(negedge clock);
    end
    do_sample("mid_after", 32'sd1024, 178);

    // Streaming: 64 back-to-back samples, one write every 4 cycles.
    begin
      longint x1 = 0;
      longint y1 = 0;
      int rd_idx = 0;
      int wr_idx = 0;
      int last   = -1;
      for (int i = 0; i < 64; i++) begin
        int v;
        v     = ((i * i * 9973) % 200003) - 100000;
        sx[i] = v * 1000;
        ex[i] = golden(sx[i], x1, y1);
        x1    = sx[i];
        y1    = ex[i];
      end
      do_reset();
      for (int cyc = 0; cyc < 400 && wr_idx < 64; cyc++) begin
        @(negedge clock);
        in_empty = (rd_idx >= 64);
        if (rd_idx < 64) in_dout = sx[rd_idx];
        #1;
        if (in_rd_en) rd_idx++;
        if (out_wr_en) begin
          check("stream_val", out_din, ex[wr_idx]);
          if (last >= 0) check("stream_gap", cyc - last, 4);
          $display("stream n=%0d y=%0d exp=%0d", wr_idx, out_din, ex[wr_idx]);
          last = cyc;
          wr_idx++;
        end
      end
      check("stream_count", wr_idx, 64);
      in_empty = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iir_deemph.md
Name: iir_deemph

Overview:
- First-order de-emphasis IIR filter in the FM audio chain.
- Sits directly upstream of the gain stage: consumes audio samples from an input FIFO and writes filtered samples into the FIFO that feeds gain.
- Fixed-point Q10 arithmetic, one output per input, no decimation.
- Transfer: y[n] = DEQUANT(B0*x[n] + B1*x[n-1] + A1*y[n-1]).

Parameters:
- DATA_SIZE, 32, sample width (signed two's complement) on input and output.
- QUANT_BITS, 10, fractional bits of coefficients; DEQUANT divides by 2^QUANT_BITS.

Ports:
- clock  input  1  single system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_dout  input  DATA_SIZE  signed sample from the upstream FIFO. First-word-fall-through: valid whenever in_empty=0.
- in_empty  input  1  upstream FIFO empty.
- in_rd_en  output  1  pop upstream FIFO. Combinational from state.
- out_din  output  DATA_SIZE  filtered signed sample to the downstream (gain) FIFO.
- out_full  input  1  downstream FIFO full.
- out_wr_en  output  1  push downstream FIFO. Combinational from state.

Behaviour:
- Interface: one clock, `clock`; reset is synchronous and active-low, on port `reset`.
- Reset (reset=0 at a clock edge):
  - state<=S_READ.
  - x_reg, x1, y1, prod0..2, y_reg <= 0.
  - out_din=0; in_rd_en=0 and out_wr_en=0 while reset is low.
- Coefficients (signed, Q10): B0=178, B1=178, A1=666 (A1 is added, not subtracted).
- Arithmetic:
  - Products are 2*DATA_SIZE bits wide, signed.
  - Sum is 2*DATA_SIZE bits wide; overflow wraps, no saturation.
- DEQUANT:
  - Signed division by 1024, truncating toward zero.
  - For a negative sum, add 1023 before the arithmetic shift right by 10.
  - Result is truncated to the low DATA_SIZE bits.
- FSM states and transitions:
  - S_READ: in_rd_en = !in_empty. If in_empty=0: x_reg<=in_dout, go to S_MULT. Otherwise stay.
  - S_MULT: prod0<=B0*x_reg, prod1<=B1*x1, prod2<=A1*y1; go to S_ACC.
  - S_ACC: y_reg<=DEQUANT(prod0+prod1+prod2); go to S_WRITE.
  - S_WRITE: out_din=y_reg; out_wr_en = !out_full. If out_full=0: x1<=x_reg, y1<=y_reg, go to S_READ. Otherwise stay, with y_reg and out_din held stable.
- Latency: the out_wr_en cycle is 3 cycles after the in_rd_en cycle when out_full=0.
- Throughput: at most 1 sample per 4 cycles.
- Backpressure:
  - While in S_WRITE with out_full=1, no new input is read and filter history is not updated.
  - No sample is dropped or duplicated.
- in_rd_en is never asserted when in_empty=1; out_wr_en is never asserted when out_full=1.
- History is updated only on a successful write, so a stall never corrupts the recursion.
- Reset mid-operation: the filter returns to S_READ, history is cleared, and an in-flight sample is discarded (not written).
- No state other than S_READ/S_MULT/S_ACC/S_WRITE is reachable; any illegal encoding recovers to S_READ.

Decomposition:
- Shared package fm_radio_pkg holds:
  - QUANT_BITS constant;
  - IIR_B0, IIR_B1, IIR_A1 coefficient constants;
  - DEQUANT function (truncate toward zero);
  - iir_state_t enum {S_READ, S_MULT, S_ACC, S_WRITE}.
- Core iir_deemph: no sub-module inside; datapath and FSM in one module.
- Wrapper iir_deemph_top instantiates two fifo instances (depth 16) around the core for standalone verification, matching the gain stage's top-level structure.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_empty=0 -> in_rd_en=0, out_wr_en=0, out_din=0. First output after release uses x1=y1=0.
- Impulse: input 1024, 0, 0 -> outputs 178, 293, 190. Exact, checked against the C golden model.
- Negative truncation: single input -1 from reset -> output 0 (toward zero, not -1). Input -1024 -> output -178.
- Backpressure: assert out_full for 5 cycles while in S_WRITE with y_reg=178 -> out_wr_en=0, in_rd_en=0, out_din stays 178. After release, exactly one write of 178, and the next sample uses y1=178.
- Streaming: 64 back-to-back samples with in_empty=0, out_full=0 -> one write every 4 cycles. All 64 match the golden model, with no gaps or duplicates.
- Mid-operation reset: pulse reset low for 1 cycle during S_ACC -> the pending sample is not written, and the next input 1024 produces 178 (history cleared).
